gray_rx_decode: RTL and testbench

Downstream consumer for the `gray_n` Gray-code counter. It synchronises an incoming N-bit Gray code and decodes it to binary. It then checks that each new value is a legal step: unchanged, or +1 with wrap. A 3-state tracker flags illegal jumps, withdraws `bin_valid` until the stream has been clean again, and counts faults.

---
 rtl/gray_rx_decode.sv | 129 ++++++++++++
 tb/tb_gray_rx_decode.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_rx_decode.sv
// Synchronises and decodes an N-bit Gray stream, checks each step (hold / +1 wrap), tracks faults.
// Latency: gray_in sampled at edge k shows in bin_out (and pulses) at edge k+SYNC_STAGES. Optional macro GRAY_RX_ERRCNT_EN.
// Backpressure: none; free-running observer that consumes one sample per clock.
module gray_rx_decode #(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] gray_in,
  input  logic         clr_err,
  output logic [N-1:0] bin_out,
  output logic         bin_valid,
  output logic         inc_pulse,
  output logic         err_pulse,
  output logic [7:0]   err_cnt
);

  localparam int WW = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  sync_q [SYNC_STAGES];
  logic [N-1:0]  s_last;
  logic [N-1:0]  d;
  logic [N-1:0]  bin_inc;
  logic          step_hold;
  logic          step_inc;
  logic          step_bad;
  logic          err_evt;
  logic [WW-1:0] wait_cnt;
  logic [1:0]    good_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s_last = sync_q[SYNC_STAGES-1];

  // Each binary bit is the parity of all Gray bits at or above it.
  always_comb begin
    d = '0;
    for (int i = 0; i < N; i++) d[i] = ^(s_last >> i);
  end

  assign bin_inc   = bin_out + N'(1);
  assign step_hold = (d == bin_out);
  assign step_inc  = (d == bin_inc);
  assign step_bad  = !step_hold && !step_inc;
  assign err_evt   = (state == TRACK) && step_bad;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= INIT;
      wait_cnt  <= '0;
      good_cnt  <= '0;
      bin_out   <= '0;
      bin_valid <= 1'b0;
      inc_pulse <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      inc_pulse <= 1'b0;
      err_pulse <= 1'b0;
      case (state)
        INIT: begin
          if (wait_cnt == WW'(SYNC_STAGES)) begin
            bin_out   <= d;
            bin_valid <= 1'b1;
            state     <= TRACK;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        TRACK: begin
          bin_out <= d;
          if (step_inc) begin
            inc_pulse <= 1'b1;
          end else if (step_bad) begin
            err_pulse <= 1'b1;
            bin_valid <= 1'b0;
            good_cnt  <= '0;
            state     <= FAULT;
          end
        end
        FAULT: begin
          bin_out <= d;
          if (step_bad) begin
            good_cnt <= '0;
          end else if (good_cnt == 2'd3) begin
            // fourth consecutive clean observation re-arms tracking
            good_cnt  <= '0;
            bin_valid <= 1'b1;
            state     <= TRACK;
          end else begin
            good_cnt <= good_cnt + 2'd1;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

`ifdef GRAY_RX_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clr_err) begin
      err_cnt <= err_evt ? 8'd1 : 8'd0;
    end else if (err_evt && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  logic unused_errcnt_inputs;
  assign unused_errcnt_inputs = clr_err ^ err_evt;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_gray_rx_decode.sv
// Randomised and directed bench for gray_rx_decode against an abstract step-classification model.
module tb_gray_rx_decode;
  localparam int N = 8;
  localparam int S = 2;
`ifdef GRAY_RX_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] gray_in = '0;
  logic         clr_err = 1'b0;
  logic [N-1:0] bin_out;
  logic         bin_valid;
  logic         inc_pulse;
  logic         err_pulse;
  logic [7:0]   err_cnt;

  gray_rx_decode #(.N(N), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .clr_err(clr_err),
    .bin_out(bin_out), .bin_valid(bin_valid), .inc_pulse(inc_pulse),
    .err_pulse(err_pulse), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: inverse Gray table, queue of in-flight samples, abstract trust mode.
  logic [7:0] g2b [256];
  logic [7:0] hist [$];
  int         m_mode;   // 0 waiting, 1 trusted, 2 recovering
  int         m_since;
  int         m_good;
  logic [7:0] m_bin;
  logic       m_valid, m_inc, m_err;
  logic [7:0] m_cnt;

  function automatic logic [7:0] gray(input int v);
    logic [7:0] b;
    b = v[7:0];
    return b ^ (b >> 1);
  endfunction

  task automatic tick(input logic [7:0] g, input logic clr, input logic rst);
    logic [7:0] dv;
    logic       is_inc, is_good;
    gray_in = g; clr_err = clr; rst_n = rst;
    @(posedge clk);
    if (!rst) begin
      hist = {};
      for (int i = 0; i < S; i++) hist.push_back(8'd0);
      m_mode = 0; m_since = 0; m_good = 0;
      m_bin = 0; m_valid = 0; m_inc = 0; m_err = 0; m_cnt = 0;
    end else begin
      dv = g2b[hist[0]];
      void'(hist.pop_front());
      hist.push_back(g);
      is_inc  = (dv == 8'(m_bin + 1));
      is_good = is_inc || (dv == m_bin);
      m_inc = 0; m_err = 0;
      case (m_mode)
        0: if (m_since == S) begin m_bin = dv; m_valid = 1; m_mode = 1; end
           else m_since++;
        1: begin
          m_bin = dv;
          if (is_inc) m_inc = 1;
          else if (!is_good) begin m_err = 1; m_valid = 0; m_good = 0; m_mode = 2; end
        end
        default: begin
          m_bin = dv;
          if (!is_good) m_good = 0;
          else begin
            m_good++;
            if (m_good == 4) begin m_valid = 1; m_mode = 1; m_good = 0; end
          end
        end
      endcase
      if (ERRCNT) begin
        if (clr) m_cnt = m_err ? 8'd1 : 8'd0;
        else if (m_err && m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
      end
    end
    #1;
  endtask

  task automatic settle(input int v);
    tick(gray(v), 1'b0, 1'b0);
    repeat (S + 3) tick(gray(v), 1'b0, 1'b1);
  endtask

  task automatic test_reset;
    int valid_edge;
    tick(gray(37), 1'b0, 1'b0);
    tick(gray(37), 1'b0, 1'b0);
    checks++; if (bin_out !== 8'd0)   begin failures++; $display("FAIL reset_bin_out got=%0d exp=0", bin_out); end
    checks++; if (bin_valid !== 1'b0) begin failures++; $display("FAIL reset_bin_valid got=%b exp=0", bin_valid); end
    checks++; if (inc_pulse !== 1'b0) begin failures++; $display("FAIL reset_inc_pulse got=%b exp=0", inc_pulse); end
    checks++; if (err_pulse !== 1'b0) begin failures++; $display("FAIL reset_err_pulse got=%b exp=0", err_pulse); end
    checks++; if (err_cnt !== 8'd0)   begin failures++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
    valid_edge = -1;
    for (int e = 1; e <= S + 4; e++) begin
      tick(gray(37), 1'b0, 1'b1);
      if (bin_valid === 1'b1 && valid_edge < 0) valid_edge = e;
    end
    checks++; if (valid_edge != S + 1) begin failures++; $display("FAIL reset_valid_latency got=%0d exp=%0d", valid_edge, S + 1); end
    checks++; if (bin_out !== 8'd37) begin failures++; $display("FAIL reset_first_value got=%0d exp=37", bin_out); end
  endtask

  task automatic test_counting;
    settle(0);
    for (int i = 1; i <= 40; i++) begin
      tick(gray(i), 1'b0, 1'b1);
      checks++;
      if ({bin_out, bin_valid, inc_pulse, err_pulse, err_cnt} !== {m_bin, m_valid, m_inc, m_err, m_cnt}) begin
        failures++;
        $display("FAIL counting i=%0d got bin=%0d v=%b inc=%b err=%b cnt=%0d exp bin=%0d v=%b inc=%b err=%b cnt=%0d",
                 i, bin_out, bin_valid, inc_pulse, err_pulse, err_cnt, m_bin, m_valid, m_inc, m_err, m_cnt);
      end
    end
    checks++; if (inc_pulse !== 1'b1) begin failures++; $display("FAIL counting_inc_high got=%b exp=1", inc_pulse); end
    checks++; if (bin_out !== 8'(40 - S)) begin failures++; $display("FAIL counting_lag got=%0d exp=%0d", bin_out, 40 - S); end
  endtask

  task automatic test_wrap;
    int vals [9] = '{251, 252, 253, 254, 255, 0, 1, 1, 1};
    int incs, errs;
    logic [7:0] prev;
    logic seen_wrap;
    settle(250);
    incs = 0; errs = 0; seen_wrap = 0; prev = bin_out;
    foreach (vals[k]) begin
      tick(gray(vals[k]), 1'b0, 1'b1);
      if (inc_pulse === 1'b1) incs++;
      if (err_pulse === 1'b1) errs++;
      if (prev == 8'd255 && bin_out === 8'd0 && inc_pulse === 1'b1) seen_wrap = 1;
      prev = bin_out;
    end
    repeat (S) begin
      tick(gray(1), 1'b0, 1'b1);
      if (inc_pulse === 1'b1) incs++;
      if (err_pulse === 1'b1) errs++;
    end
    checks++; if (incs != 7) begin failures++; $display("FAIL wrap_inc_count got=%0d exp=7", incs); end
    checks++; if (errs != 0) begin failures++; $display("FAIL wrap_err_count got=%0d exp=0", errs); end
    checks++; if (seen_wrap !== 1'b1) begin failures++; $display("FAIL wrap_255_to_0 got=%b exp=1", seen_wrap); end
  endtask

  task automatic test_jump;
    int errs, incs, rise;
    settle(5);
    errs = 0; incs = 0; rise = -1;
    for (int t = 1; t <= S + 7; t++) begin
      tick(gray(9), 1'b0, 1'b1);
      if (err_pulse === 1'b1) errs++;
      if (inc_pulse === 1'b1) incs++;
      if (t > S && bin_valid === 1'b1 && rise < 0) rise = t;
      checks++;
      if ({bin_out, bin_valid, inc_pulse, err_pulse, err_cnt} !== {m_bin, m_valid, m_inc, m_err, m_cnt}) begin
        failures++;
        $display("FAIL jump t=%0d got bin=%0d v=%b inc=%b err=%b cnt=%0d exp bin=%0d v=%b inc=%b err=%b cnt=%0d",
                 t, bin_out, bin_valid, inc_pulse, err_pulse, err_cnt, m_bin, m_valid, m_inc, m_err, m_cnt);
      end
    end
    checks++; if (errs != 1) begin failures++; $display("FAIL jump_err_count got=%0d exp=1", errs); end
    checks++; if (incs != 0) begin failures++; $display("FAIL jump_inc_count got=%0d exp=0", incs); end
    checks++; if (rise != S + 5) begin failures++; $display("FAIL jump_recover_cycle got=%0d exp=%0d", rise, S + 5); end
    checks++; if (err_cnt !== (ERRCNT ? 8'd1 : 8'd0)) begin failures++; $display("FAIL jump_err_cnt got=%0d exp=%0d", err_cnt, ERRCNT ? 1 : 0); end
  endtask

  task automatic test_reversal;
    int seq [13] = '{9, 9, 9, 20, 20, 20, 20, 20, 20, 20, 20, 20, 20};
    int errs, rise;
    settle(10);
    errs = 0; rise = -1;
    foreach (seq[k]) begin
      tick(gray(seq[k]), 1'b0, 1'b1);
      if (err_pulse === 1'b1) errs++;
      if (k + 1 > S + 1 && bin_valid === 1'b1 && rise < 0) rise = k + 1;
      checks++;
      if ({bin_out, bin_valid, inc_pulse, err_pulse, err_cnt} !== {m_bin, m_valid, m_inc, m_err, m_cnt}) begin
        failures++;
        $display("FAIL reversal t=%0d got bin=%0d v=%b inc=%b err=%b exp bin=%0d v=%b inc=%b err=%b",
                 k + 1, bin_out, bin_valid, inc_pulse, err_pulse, m_bin, m_valid, m_inc, m_err);
      end
    end
    checks++; if (errs != 1) begin failures++; $display("FAIL reversal_err_count got=%0d exp=1", errs); end
    checks++; if (rise != S + 8) begin failures++; $display("FAIL reversal_recover_cycle got=%0d exp=%0d", rise, S + 8); end
  endtask

  task automatic test_saturation;
    int v, j;
    settle(0);
    v = 0;
    for (int i = 0; i < 1400; i++) begin
      v = ((i / 5) % 2 == 1) ? 128 : 0;
      tick(gray(v), 1'b0, 1'b1);
      checks++;
      if ({bin_out, bin_valid, inc_pulse, err_pulse, err_cnt} !== {m_bin, m_valid, m_inc, m_err, m_cnt}) begin
        failures++;
        $display("FAIL saturation i=%0d got bin=%0d v=%b err=%b cnt=%0d exp bin=%0d v=%b err=%b cnt=%0d",
                 i, bin_out, bin_valid, err_pulse, err_cnt, m_bin, m_valid, m_err, m_cnt);
      end
    end
    checks++; if (err_cnt !== (ERRCNT ? 8'd255 : 8'd0)) begin failures++; $display("FAIL saturation_stop got=%0d exp=%0d", err_cnt, ERRCNT ? 255 : 0); end
    repeat (6) tick(gray(v), 1'b0, 1'b1);
    j = v ^ 8'h55;
    repeat (S) tick(gray(j), 1'b0, 1'b1);
    tick(gray(j), 1'b1, 1'b1);
    checks++; if (err_pulse !== 1'b1) begin failures++; $display("FAIL clear_with_error_pulse got=%b exp=1", err_pulse); end
    checks++; if (err_cnt !== (ERRCNT ? 8'd1 : 8'd0)) begin failures++; $display("FAIL clear_with_error_cnt got=%0d exp=%0d", err_cnt, ERRCNT ? 1 : 0); end
    tick(gray(j), 1'b1, 1'b1);
    checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL clear_alone got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_reset_mid_fault;
    int errs;
    settle(30);
    tick(gray(31), 1'b0, 1'b1);
    repeat (S + 1) tick(gray(60), 1'b0, 1'b1);
    checks++; if (bin_valid !== 1'b0) begin failures++; $display("FAIL midreset_in_fault got=%b exp=0", bin_valid); end
    tick(gray(60), 1'b0, 1'b0);
    checks++;
    if ({bin_out, bin_valid, inc_pulse, err_pulse, err_cnt} !== 19'd0) begin
      failures++;
      $display("FAIL midreset_outputs got bin=%0d v=%b inc=%b err=%b cnt=%0d exp all 0",
               bin_out, bin_valid, inc_pulse, err_pulse, err_cnt);
    end
    errs = 0;
    for (int i = 61; i < 61 + S + 6; i++) begin
      tick(gray(i), 1'b0, 1'b1);
      if (err_pulse === 1'b1) errs++;
      checks++;
      if ({bin_out, bin_valid, inc_pulse, err_pulse, err_cnt} !== {m_bin, m_valid, m_inc, m_err, m_cnt}) begin
        failures++;
        $display("FAIL midreset_recover i=%0d got bin=%0d v=%b inc=%b err=%b exp bin=%0d v=%b inc=%b err=%b",
                 i, bin_out, bin_valid, inc_pulse, err_pulse, m_bin, m_valid, m_inc, m_err);
      end
    end
    checks++; if (errs != 0) begin failures++; $display("FAIL midreset_err_count got=%0d exp=0", errs); end
    checks++; if (bin_valid !== 1'b1) begin failures++; $display("FAIL midreset_valid_back got=%b exp=1", bin_valid); end
  endtask

  task automatic test_random;
    int v, r;
    logic clr, rst;
    v = $urandom_range(0, 255);
    settle(v);
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 4)      v = (v + 1) % 256;
      else if (r == 8) v = $urandom_range(0, 255);
      else if (r == 9) v = (v + 255) % 256;
      clr = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 299) != 0);
      tick(gray(v), clr, rst);
      checks++;
      if ({bin_out, bin_valid, inc_pulse, err_pulse, err_cnt} !== {m_bin, m_valid, m_inc, m_err, m_cnt}) begin
        failures++;
        $display("FAIL random i=%0d got bin=%0d v=%b inc=%b err=%b cnt=%0d exp bin=%0d v=%b inc=%b err=%b cnt=%0d",
                 i, bin_out, bin_valid, inc_pulse, err_pulse, err_cnt, m_bin, m_valid, m_inc, m_err, m_cnt);
      end
    end
  endtask

  initial begin
    logic [7:0] bb;
    for (int b = 0; b < 256; b++) begin
      bb = 8'(b);
      g2b[bb ^ (bb >> 1)] = bb;
    end
    test_reset;
    test_counting;
    test_wrap;
    test_jump;
    test_reversal;
    test_saturation;
    test_reset_mid_fault;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
